cmp_minmax_seq: RTL
===================

# cmp_minmax_seq

Sequencer that time-shares one 5-bit greater-than comparator to find the maximum and minimum of a burst of operands. Operands arrive one at a time over a valid/ready stream. Results are reported with the positions of the winning operands and a one-cycle done pulse. It sits in front of the magnitude-comparator datapath and is the only user of its inputs.

## Interface
- W, 5, operand width; equals the comparator width.
- CNT_W, 4, burst-length and index width; maximum burst length is 2^CNT_W−1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a burst; sampled only in IDLE.
- len  in  CNT_W  number of operands in the burst; latched with start.
- in_valid  in  1  operand present on in_data.
- in_data  in  W  unsigned operand.
- in_ready  out  1  block accepts in_data this cycle; a transfer happens when in_valid && in_ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse; results valid from this cycle onward.
- max_out  out  W  largest operand.
- max_idx  out  CNT_W  0-based position of max_out in the burst.
- min_out  out  W  smallest operand.
- min_idx  out  CNT_W  0-based position of min_out in the burst.

## Operation
- States: IDLE, FIRST, WAIT, CMP_MAX, CMP_MIN, DONE.
- IDLE
  - in_ready=0.
  - start=1 and len≠0: latch len, clear count, go to FIRST.
  - start=1 and len=0: clear all result registers to 0, go to DONE.
- FIRST
  - in_ready=1.
  - On transfer: max_r=min_r=in_data, max_idx=min_idx=0, count=1.
  - Then go to DONE if len==1, else WAIT.
- WAIT
  - in_ready=1.
  - On transfer: op_r=in_data, go to CMP_MAX. Otherwise stay.
- CMP_MAX
  - Comparator a=op_r, b=max_r.
  - If gt: max_r=op_r, max_idx=count.
  - Go to CMP_MIN.
- CMP_MIN
  - Comparator a=min_r, b=op_r.
  - If gt: min_r=op_r, min_idx=count.
  - count+=1. Go to DONE if count+1==len, else WAIT.
- DONE: done=1; go to IDLE.
- Comparisons are strict greater-than, so on ties the earliest operand keeps both max and min.
- Comparator inputs are driven only from registered values, never from in_data. In states other than CMP_MAX and CMP_MIN the inputs are don't-care.
- Results are held from DONE until the next accepted start, and are overwritten only as a new burst progresses.
- start outside IDLE is ignored. The new len is not latched.
- count is CNT_W bits. It never wraps because len ≤ 2^CNT_W−1.

## Timing
- Reset values: in_ready=0, busy=0, done=0, max_out=0, max_idx=0, min_out=0, min_idx=0; state=IDLE, count=0.
- Reset asserted mid-burst: immediate return to IDLE with the reset values. The partial burst is discarded. No done pulse is produced.
- Start sampled in cycle 0. With no in_valid stalls:
  - First operand accepted in cycle 1.
  - Each later operand takes 3 cycles (WAIT, CMP_MAX, CMP_MIN).
  - DONE occurs in cycle 3·len−1.
- len=0: DONE in cycle 1.
- Each in_valid stall extends WAIT or FIRST by one cycle per stalled cycle.
- in_ready is a registered-state decode. It does not depend combinationally on in_valid.
- done is high for exactly one cycle per accepted start.

## Structure
- Shared package holds:
  - W, CNT_W defaults.
  - Enumerated state encoding (IDLE..DONE, 3 bits).
- One natural sub-module: mag_cmp5_gt. It is a combinational W-bit unsigned a>b comparator with ports a, b, gt, instantiated once and operand-muxed by state.
- Everything else (FSM, operand, result and index registers, counter) is in the top module.

## Test plan
- Burst len=4, data 7,31,0,12, in_valid held high → max_out=31, max_idx=1, min_out=0, min_idx=2; done in cycle 11.
- Tie burst len=3, data 9,9,9 → max_out=min_out=9, max_idx=min_idx=0.
- len=1, data 5 → max_out=min_out=5, both indices 0; done in cycle 2.
- len=0 → done in cycle 1, all result outputs 0, in_ready never high.
- len=2, data 3 then 20, with 4 idle cycles before the second in_valid, and start pulsed while busy:
  - Results max 20/idx1, min 3/idx0.
  - done in cycle 9.
  - Extra start ignored, no second done.
- rst asserted during CMP_MAX of a len=5 burst → outputs 0, busy=0 next edge, no done. A following len=2 burst (1, 2) then gives max 2/idx1, min 1/idx0.

Source files
------------

// File: rtl/cmp_minmax_seq_pkg.sv
// Shared widths and FSM state encoding for the min/max sequencer.
package cmp_minmax_seq_pkg;

  localparam int DEF_W     = 5;
  localparam int DEF_CNT_W = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FIRST   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CMP_MAX = 3'd3;
  localparam logic [2:0] S_CMP_MIN = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

endpackage

// File: rtl/mag_cmp5_gt.sv
// Combinational unsigned a > b magnitude comparator.
module mag_cmp5_gt #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt
);

  assign gt = (a > b);

endmodule

// File: rtl/cmp_minmax_seq.sv
// Burst min/max finder sharing a single greater-than comparator across two
// compare states per operand; results and winning positions held until next start.
module cmp_minmax_seq
  import cmp_minmax_seq_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     max_out,
  output logic [CNT_W-1:0] max_idx,
  output logic [W-1:0]     min_out,
  output logic [CNT_W-1:0] min_idx
);

  localparam logic [CNT_W-1:0] ONE = 1;

  logic [2:0]       state;
  logic [CNT_W-1:0] len_r;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic [W-1:0]     op_r;
  logic [W-1:0]     max_r;
  logic [W-1:0]     min_r;
  logic [CNT_W-1:0] max_idx_r;
  logic [CNT_W-1:0] min_idx_r;
  logic [W-1:0]     cmp_a;
  logic [W-1:0]     cmp_b;
  logic             gt;

  assign count_inc = count + ONE;

  // Only registered values reach the comparator; operands swap roles for the min pass.
  always_comb begin
    cmp_a = min_r;
    cmp_b = op_r;
    if (state == S_CMP_MAX) begin
      cmp_a = op_r;
      cmp_b = max_r;
    end
  end

  mag_cmp5_gt #(.W(W)) u_cmp (
    .a  (cmp_a),
    .b  (cmp_b),
    .gt (gt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      len_r     <= '0;
      count     <= '0;
      op_r      <= '0;
      max_r     <= '0;
      min_r     <= '0;
      max_idx_r <= '0;
      min_idx_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              len_r <= len;
              count <= '0;
              state <= S_FIRST;
            end else begin
              max_r     <= '0;
              min_r     <= '0;
              max_idx_r <= '0;
              min_idx_r <= '0;
              state     <= S_DONE;
            end
          end
        end
        S_FIRST: begin
          if (in_valid) begin
            max_r     <= in_data;
            min_r     <= in_data;
            max_idx_r <= '0;
            min_idx_r <= '0;
            count     <= ONE;
            state     <= (len_r == ONE) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (in_valid) begin
            op_r  <= in_data;
            state <= S_CMP_MAX;
          end
        end
        S_CMP_MAX: begin
          if (gt) begin
            max_r     <= op_r;
            max_idx_r <= count;
          end
          state <= S_CMP_MIN;
        end
        S_CMP_MIN: begin
          if (gt) begin
            min_r     <= op_r;
            min_idx_r <= count;
          end
          count <= count_inc;
          state <= (count_inc == len_r) ? S_DONE : S_WAIT;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready = (state == S_FIRST) || (state == S_WAIT);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign max_out  = max_r;
  assign max_idx  = max_idx_r;
  assign min_out  = min_r;
  assign min_idx  = min_idx_r;

endmodule
